dot_product_acc_4x4: RTL

Sequential dot-product engine built around the existing `array_multiplier_4x4`. It accepts a stream of 4-bit operand pairs over a valid/ready handshake and multiplies each pair. It registers each 8-bit product and accumulates VEC_LEN products into one result. The result is presented on a valid/ready output port, and the block holds it until it is consumed. It sits directly downstream of the multiplier and consumes `product_o` every accepted beat.

---
 rtl/dot_acc_pkg.sv | 16 +
 rtl/array_multiplier_4x4.sv | 39 +++
 rtl/dot_product_acc_4x4.sv | 104 ++++++++++
 3 files changed

// File: rtl/dot_acc_pkg.sv
// Shared types and helpers for the dot-product accumulator.
package dot_acc_pkg;

   // Result-path states: accumulate, fold in the last product, present result.
   typedef enum logic [1:0] {
      S_ACC   = 2'd0,
      S_FLUSH = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   // Width that holds vec_len full-scale 8-bit products without overflow.
   function automatic int acc_width(input int vec_len);
      return 8 + $clog2(vec_len);
   endfunction

endpackage

// File: rtl/array_multiplier_4x4.sv
// Unsigned 4x4 array multiplier: AND-gate partial products summed by
// rows of ripple-carry full adders, one row per bit of b_i.
module array_multiplier_4x4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [7:0] product_o
);

   logic [3:0] run;    // running partial sum, aligned to the current row weight
   logic [3:0] pp;     // partial product of the current row
   logic [4:0] sum;    // current row adder output
   logic       carry;  // ripple carry inside a row

   // Add each partial-product row into the running sum, retiring one LSB per row.
   always_comb begin
      // NOTE: every variable gets a value before any branch or loop reads it, so
      // no storage is implied; blocking '=' is correct here because each
      // statement consumes the value produced by the previous one.
      product_o = '0;
      pp        = a_i & {4{b_i[0]}};
      sum       = '0;
      carry     = 1'b0;
      product_o[0] = pp[0];
      run       = {1'b0, pp[3:1]};
      for (int i = 1; i < 4; i++) begin
         pp    = a_i & {4{b_i[i]}};
         carry = 1'b0;
         for (int j = 0; j < 4; j++) begin
            sum[j] = run[j] ^ pp[j] ^ carry;
            carry  = (run[j] & pp[j]) | (carry & (run[j] ^ pp[j]));
         end
         sum[4]       = carry;
         product_o[i] = sum[0];
         run          = sum[4:1];
      end
      product_o[7:4] = run;
   end

endmodule

// File: rtl/dot_product_acc_4x4.sv
// Sequential dot-product engine: multiplies a stream of 4-bit operand pairs,
// accumulates VEC_LEN registered products and hands the sum off over a
// valid/ready port, holding it until consumed.
module dot_product_acc_4x4
   import dot_acc_pkg::*;
#(
   parameter  int VEC_LEN = 8,
   localparam int ACC_W   = acc_width(VEC_LEN)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic [3:0]       a_i,
   input  logic [3:0]       b_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [ACC_W-1:0] result_o,
   output logic             valid_o,
   input  logic             ready_i
);

   // A one-bit counter still works for VEC_LEN == 1; it simply never advances.
   localparam int              CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(VEC_LEN - 1);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [7:0]         prod_q;
   logic               prod_vld_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   result_q;
   logic [7:0]         product;
   logic               accept;

   array_multiplier_4x4 u_mult (
      .a_i       (a_i),
      .b_i       (b_i),
      .product_o (product)
   );

   // Outputs decode only from registers; no input reaches an output combinationally.
   assign ready_o  = (state_q == S_ACC);
   assign valid_o  = (state_q == S_OUT);
   assign result_o = result_q;

   // A pair is taken only while accumulating and never in a clear cycle.
   assign accept = valid_i && (state_q == S_ACC) && !clear_i;

   // Control: vector beat counter and result-handshake state machine.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: registers use non-blocking '<=' so every flop samples the values
      // from before the edge, independent of statement order.
      if (!rst_ni) begin
         state_q <= S_ACC;
         cnt_q   <= '0;
      end else if (clear_i) begin
         state_q <= S_ACC;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            S_ACC: begin
               if (accept) begin
                  if (cnt_q == LAST) begin
                     cnt_q   <= '0;
                     state_q <= S_FLUSH;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_FLUSH: state_q <= S_OUT;
            S_OUT:   if (ready_i) state_q <= S_ACC;
            default: state_q <= S_ACC;
         endcase
      end
   end

   // Datapath: product register, accumulator and held result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
         result_q   <= '0;
      end else if (clear_i) begin
         // The held result survives an abort; only the partial vector is dropped.
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
      end else begin
         prod_vld_q <= accept;
         if (accept) begin
            prod_q <= product;
         end
         if (state_q == S_FLUSH) begin
            // The last product is still in prod_q; fold it in directly.
            result_q <= acc_q + ACC_W'(prod_q);
            acc_q    <= '0;
         end else if (prod_vld_q) begin
            acc_q <= acc_q + ACC_W'(prod_q);
         end
      end
   end

endmodule
